baud_tick_ctrl: RTL and testbench

Runtime-configurable baud-rate tick scheduler for the UART. It replaces fixed-ratio derived clocks with single-cycle enable pulses on the system clock. It produces a 16x oversample tick for the RX sampler and a 1x bit tick for TX and RX. It owns the divisor register, accepts new divisors through a valid/ready handshake, applies them only at a bit boundary, and re-phases on RX start-bit detection.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/baud_prescaler.sv | 39 +++
 rtl/baud_tick_ctrl.sv | 122 ++++++++++++
 tb/tb_baud_tick_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types: baud-tick FSM states and divisor defaults.
package uart_pkg;

  localparam int unsigned CLOCK_INPUT = 50_000_000;
  localparam int unsigned BAUD_RATE   = 115_200;
  localparam int unsigned DIV_W       = 16;
  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MIN_DIV     = 2;

  // Prescaler divisor that yields BAUD_RATE at the given oversample ratio.
  function automatic int unsigned default_div(input int unsigned clk_hz, input int unsigned os);
    return clk_hz / (BAUD_RATE * os);
  endfunction

  localparam int unsigned DEFAULT_DIV = default_div(CLOCK_INPUT, OVERSAMPLE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } baud_state_t;

endpackage

// File: rtl/baud_prescaler.sv
// Runtime-modulus counter: counts 0..max_i, with clear and preset; wrap_o marks the
// increment that rolls back to zero.
module baud_prescaler #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [Width-1:0] max_i,
  output logic             wrap_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign wrap_o = inc_i && (cnt_q == max_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/baud_tick_ctrl.sv
// Baud tick scheduler: single-cycle oversample and bit enables from a runtime divisor,
// with divisor changes deferred to a bit boundary and re-phasing on RX start bits.
module baud_tick_ctrl #(
  parameter int unsigned CLOCK_INPUT = uart_pkg::CLOCK_INPUT,
  parameter int unsigned DIV_W       = uart_pkg::DIV_W,
  parameter int unsigned OVERSAMPLE  = uart_pkg::OVERSAMPLE,
  parameter int unsigned DEFAULT_DIV = uart_pkg::default_div(CLOCK_INPUT, OVERSAMPLE)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             ena,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             rx_resync,
  output logic             os_tick,
  output logic             bit_tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             active
);
  import uart_pkg::*;

  localparam int unsigned OsW = $clog2(OVERSAMPLE);

  baud_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             os_tick_q, bit_tick_q;
  logic [DIV_W-1:0] cfg_div_clamped;
  logic             running, count_en, cfg_fire;
  logic             pre_clr, os_clr, pre_wrap, os_wrap;

  assign running   = (state_q != IDLE);
  assign cfg_ready = (state_q != PEND);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_div_clamped = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;

  // A resync sample suppresses any wrap due on the same edge.
  assign count_en = running && ena && !rx_resync;
  assign pre_clr  = !running || !ena || rx_resync;
  assign os_clr   = !running || !ena;

  baud_prescaler #(
    .Width (DIV_W)
  ) u_pre (
    .clk_i      (clock),
    .rst_ni     (nreset),
    .clr_i      (pre_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (count_en),
    .max_i      (div_q - DIV_W'(1)),
    .wrap_o     (pre_wrap)
  );

  // Resync presets to mid-bit so the next bit tick lands in the middle of the start bit.
  baud_prescaler #(
    .Width (OsW)
  ) u_os (
    .clk_i      (clock),
    .rst_ni     (nreset),
    .clr_i      (os_clr),
    .load_i     (rx_resync),
    .load_val_i (OsW'(OVERSAMPLE / 2)),
    .inc_i      (pre_wrap),
    .max_i      (OsW'(OVERSAMPLE - 1)),
    .wrap_o     (os_wrap)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_fire) div_d = cfg_div_clamped;
        if (ena) state_d = RUN;
      end
      RUN: begin
        if (!ena) begin
          state_d = IDLE;
          if (cfg_fire) div_d = cfg_div_clamped;
        end else if (cfg_fire) begin
          pend_d  = cfg_div_clamped;
          state_d = PEND;
        end
      end
      PEND: begin
        if (!ena) begin
          div_d   = pend_q;
          state_d = IDLE;
        end else if (rx_resync || os_wrap) begin
          div_d   = pend_q;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      div_q      <= DIV_W'(DEFAULT_DIV);
      pend_q     <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      os_tick_q  <= pre_wrap;
      bit_tick_q <= os_wrap;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign cur_div  = div_q;
  assign active   = running;

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Bench for baud_tick_ctrl: cycle-by-cycle comparison against an arithmetic tick model,
// plus directed timing checks with hand-computed delays.
module tb_baud_tick_ctrl;

  localparam int OS  = 16;
  localparam int DEF = 4;
  localparam int DW  = 16;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          ena = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic          rx_resync = 1'b0;
  logic          cfg_ready, os_tick, bit_tick, active;
  logic [DW-1:0] cur_div;

  baud_tick_ctrl #(
    .DIV_W       (DW),
    .OVERSAMPLE  (OS),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clock     (clock),
    .nreset    (nreset),
    .ena       (ena),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .rx_resync (rx_resync),
    .os_tick   (os_tick),
    .bit_tick  (bit_tick),
    .cur_div   (cur_div),
    .active    (active)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // Model: k counts edges since the last phase origin; os ticks fall on multiples of div,
  // bit ticks where the os index (offset by base) is a multiple of OS.
  int m_run = 0, m_pv = 0, m_div = DEF, m_pend = 0, m_k = 0, m_base = 0;
  bit e_os = 1'b0, e_bit = 1'b0, fire;

  always @(posedge clock) begin
    e_os  = 1'b0;
    e_bit = 1'b0;
    if (!nreset) begin
      m_run = 0; m_pv = 0; m_div = DEF; m_k = 0; m_base = 0;
    end else begin
      fire = cfg_valid && (m_pv == 0);
      if (m_run == 0) begin
        if (fire) m_div = clampd(int'(cfg_div));
        if (ena) begin
          m_run = 1; m_k = 0; m_base = 0;
        end
      end else if (!ena) begin
        m_run = 0;
        if (m_pv != 0) begin
          m_div = m_pend; m_pv = 0;
        end else if (fire) begin
          m_div = clampd(int'(cfg_div));
        end
      end else begin
        if (rx_resync) begin
          m_k = 0; m_base = OS / 2;
          if (m_pv != 0) begin
            m_div = m_pend; m_pv = 0;
          end
        end else begin
          m_k++;
          if (m_k % m_div == 0) begin
            e_os = 1'b1;
            if ((m_base + m_k / m_div) % OS == 0) begin
              e_bit = 1'b1; m_k = 0; m_base = 0;
              if (m_pv != 0) begin
                m_div = m_pend; m_pv = 0;
              end
            end
          end
        end
        if (fire) begin
          m_pend = clampd(int'(cfg_div)); m_pv = 1;
        end
      end
    end
    #1;
    chk("os_tick", os_tick, e_os);
    chk("bit_tick", bit_tick, e_bit);
    chk("active", active, m_run);
    chk("cfg_ready", cfg_ready, (m_pv == 0) ? 1 : 0);
    chk("cur_div", cur_div, m_div);
  end

  task automatic wait_tick(input bit want_bit, input string name, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      if (want_bit ? bit_tick : os_tick) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no tick within 400 cycles, required one", name);
      at = cyc;
    end
  endtask

  initial begin
    int t0, o, o2, b1, b2, b3, b4;

    repeat (3) @(posedge clock);
    #1;
    chk("reset os_tick", os_tick, 0);
    chk("reset bit_tick", bit_tick, 0);
    chk("reset active", active, 0);
    chk("reset cfg_ready", cfg_ready, 1);
    chk("reset cur_div", cur_div, DEF);
    @(negedge clock) nreset = 1'b1;

    // Default divisor, free running
    @(negedge clock); ena = 1'b1; t0 = cyc;
    wait_tick(0, "first os", o);   chk("first os delay", o - t0, 5);
    wait_tick(0, "os", o2);        chk("os period div4", o2 - o, 4);
    wait_tick(1, "first bit", b1); chk("first bit delay", b1 - t0, 65);
    wait_tick(1, "bit", b2);       chk("bit period div4", b2 - b1, 64);

    // Divisor change deferred to the bit boundary
    repeat (3) wait_tick(0, "os", o);
    @(negedge clock); cfg_valid = 1'b1; cfg_div = 16'd6;
    @(negedge clock); cfg_valid = 1'b0;
    chk("cfg_ready while pending", cfg_ready, 0);
    chk("cur_div before apply", cur_div, 4);
    wait_tick(0, "os", o2);        chk("old os spacing kept", o2 - o, 4);
    wait_tick(1, "bit", b3);       chk("bit before apply", b3 - b2, 64);
    chk("cur_div applied", cur_div, 6);
    wait_tick(0, "os", o);         chk("os period div6", o - b3, 6);
    wait_tick(1, "bit", b4);       chk("bit period div6", b4 - b3, 96);

    // Resync at an arbitrary phase with div 4
    @(negedge clock); cfg_valid = 1'b1; cfg_div = 16'd4;
    @(negedge clock); cfg_valid = 1'b0;
    wait_tick(1, "bit", b1);
    chk("cur_div back to 4", cur_div, 4);
    repeat ($urandom_range(1, 40)) @(negedge clock);
    rx_resync = 1'b1; t0 = cyc;
    @(negedge clock); rx_resync = 1'b0;
    wait_tick(0, "resync os", o);  chk("resync os delay", o - t0, 5);
    wait_tick(1, "resync bit", b1); chk("resync bit delay", b1 - t0, 33);
    wait_tick(1, "bit", b2);       chk("bit period after resync", b2 - b1, 64);

    // Clamped divisor loaded in IDLE
    @(negedge clock); ena = 1'b0;
    @(negedge clock); cfg_valid = 1'b1; cfg_div = 16'd0;
    @(negedge clock); cfg_valid = 1'b0;
    chk("idle clamp cur_div", cur_div, 2);
    chk("idle active", active, 0);
    ena = 1'b1; t0 = cyc;
    wait_tick(0, "os", o);         chk("first os div2", o - t0, 3);
    wait_tick(0, "os", o2);        chk("os period div2", o2 - o, 2);

    // ena dropped while a divisor is pending
    @(negedge clock); cfg_valid = 1'b1; cfg_div = 16'd10;
    @(negedge clock); cfg_valid = 1'b0;
    chk("pend cfg_ready", cfg_ready, 0);
    ena = 1'b0;
    @(posedge clock); #1;
    chk("stop os_tick", os_tick, 0);
    chk("stop bit_tick", bit_tick, 0);
    chk("stop active", active, 0);
    chk("stop cur_div", cur_div, 10);
    chk("stop cfg_ready", cfg_ready, 1);

    // Asynchronous reset mid-bit with a pending divisor
    @(negedge clock); ena = 1'b1;
    repeat (15) @(negedge clock);
    cfg_valid = 1'b1; cfg_div = 16'd7;
    @(negedge clock); cfg_valid = 1'b0;
    chk("pend7 cfg_ready", cfg_ready, 0);
    repeat (20) @(negedge clock);
    #2 nreset = 1'b0;
    #1;
    chk("async rst os_tick", os_tick, 0);
    chk("async rst bit_tick", bit_tick, 0);
    chk("async rst active", active, 0);
    chk("async rst cfg_ready", cfg_ready, 1);
    chk("async rst cur_div", cur_div, DEF);
    @(negedge clock); nreset = 1'b1; t0 = cyc;
    wait_tick(0, "os after reset", o);
    chk("os delay after reset", o - t0, 5);
    chk("pending discarded", cur_div, DEF);

    // Random traffic without resync, then with every event mixed in
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      nreset    = ($urandom_range(0, 1999) != 0);
      ena       = ($urandom_range(0, 199) != 0);
      cfg_valid = ($urandom_range(0, 99) < 3);
      cfg_div   = DW'($urandom_range(0, 9));
      rx_resync = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      nreset    = ($urandom_range(0, 999) != 0);
      ena       = ($urandom_range(0, 99) != 0);
      cfg_valid = ($urandom_range(0, 99) < 4);
      cfg_div   = DW'($urandom_range(0, 9));
      rx_resync = ($urandom_range(0, 99) < 2);
    end
    @(negedge clock);
    nreset = 1'b1; cfg_valid = 1'b0; rx_resync = 1'b0;
    repeat (4) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
